// File: rtl/sseg_scan.sv
// Four-digit time-multiplexed scanner for a common-anode seven-segment display.
// Holds a frame-synchronised hex value and dp flags and emits one digit slot at a time,
// with a blanking guard at the start of each slot and optional leading-zero suppression.
module sseg_scan #(
    parameter int unsigned REFRESH_BITS = 18,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        dp
);

    localparam int unsigned PH_W = REFRESH_BITS - 2;
    localparam logic [PH_W-1:0] BLANK_PH = PH_W'(BLANK_CYCLES);

    logic [REFRESH_BITS-1:0] r_cnt;
    logic [15:0]             r_pend_val;
    logic [3:0]              r_pend_dp;
    logic [15:0]             r_act_val;
    logic [3:0]              r_act_dp;
    logic [3:0]              r_an;
    logic [3:0]              r_digit;
    logic                    r_dp;

    logic [1:0]              w_sel;
    logic [PH_W-1:0]         w_ph;
    logic                    w_frame_end;
    logic [3:0]              w_supp;
    logic [3:0]              w_digit;
    logic [3:0]              w_an;
    logic                    w_dp;
    logic                    w_z3;
    logic                    w_z2;
    logic                    w_z1;

    assign w_sel       = r_cnt[REFRESH_BITS-1 -: 2];
    assign w_ph        = r_cnt[PH_W-1:0];
    assign w_frame_end = &r_cnt;

    // Free-running scan counter; wraps naturally from all-ones to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + REFRESH_BITS'(1);
        end
    end

    // Pending capture on every load; active copy only at the frame boundary (load bypasses pend).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_val <= 16'h0000;
            r_pend_dp  <= 4'h0;
            r_act_val  <= 16'h0000;
            r_act_dp   <= 4'h0;
        end else begin
            if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
            end
            if (w_frame_end) begin
                r_act_val <= load ? value : r_pend_val;
                r_act_dp  <= load ? dp_in : r_pend_dp;
            end
        end
    end

    // Digit/dp/anode selection for the current slot, including blanking guard and zero mask.
    always_comb begin
        w_digit = 4'h0;
        w_an    = 4'hF;
        w_dp    = 1'b1;
        w_z3    = (r_act_val[15:12] == 4'h0);
        w_z2    = w_z3 & (r_act_val[11:8] == 4'h0);
        w_z1    = w_z2 & (r_act_val[7:4] == 4'h0);
        w_supp  = {blank_lz & w_z3, blank_lz & w_z2, blank_lz & w_z1, 1'b0};
        case (w_sel)
            2'd0:    w_digit = r_act_val[3:0];
            2'd1:    w_digit = r_act_val[7:4];
            2'd2:    w_digit = r_act_val[11:8];
            default: w_digit = r_act_val[15:12];
        endcase
        w_dp = ~r_act_dp[w_sel];
        if ((w_ph >= BLANK_PH) && !w_supp[w_sel]) begin
            w_an = ~(4'b0001 << w_sel);
        end
    end

    // Output registers: one clock of latency from the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an    <= 4'hF;
            r_digit <= 4'h0;
            r_dp    <= 1'b1;
        end else begin
            r_an    <= w_an;
            r_digit <= w_digit;
            r_dp    <= w_dp;
        end
    end

    assign an    = r_an;
    assign digit = r_digit;
    assign dp    = r_dp;

endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan with a 64-clock frame (16-clock slots, 2-clock blanking guard).
module tb_sseg_scan;

    localparam int RB = 6;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        dp;

    sseg_scan #(.REFRESH_BITS(RB), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .an(an), .digit(digit), .dp(dp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycle position within the frame, pending and displayed values.
    int          m_cnt = 0;
    int          last_cnt = -1;
    logic [15:0] m_pend = 16'h0;
    logic [15:0] m_act  = 16'h0;
    logic [3:0]  m_pdp  = 4'h0;
    logic [3:0]  m_adp  = 4'h0;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpi;
        logic        blz;
        logic [3:0]  lit;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one clock of inputs, predict the outputs from the frame arithmetic, compare after the edge.
    task automatic step(input logic rst, input logic ld, input logic [15:0] v, input logic [3:0] d);
        logic [3:0]  e_an;
        logic [3:0]  e_dig;
        logic        e_dp;
        logic [15:0] upper;
        logic        one_low;
        int s;
        int ph;
        reset = rst;
        load  = ld;
        value = v;
        dp_in = d;
        if (rst) begin
            e_an = 4'hF; e_dig = 4'h0; e_dp = 1'b1;
            last_cnt = -1; m_cnt = 0;
            m_pend = 16'h0; m_act = 16'h0; m_pdp = 4'h0; m_adp = 4'h0;
        end else begin
            s     = m_cnt / 16;
            ph    = m_cnt % 16;
            upper = m_act >> (4 * s);
            e_dig = upper[3:0];
            e_dp  = ~m_adp[s];
            if (ph < BC || (blank_lz && s > 0 && upper == 16'h0)) e_an = 4'hF;
            else e_an = ~(4'(1) << s);
            last_cnt = m_cnt;
            if (m_cnt == 63) begin
                m_act = ld ? v : m_pend;
                m_adp = ld ? d : m_pdp;
            end
            if (ld) begin
                m_pend = v;
                m_pdp  = d;
            end
            m_cnt = (m_cnt + 1) % 64;
        end
        @(posedge clk);
        #1;
        check("model_an", an, e_an);
        check("model_digit", digit, e_dig);
        check("model_dp", dp, e_dp);
        one_low = ($countones(~an) <= 1);
        check("an_one_hot_low", one_low, 1);
    endtask

    task automatic run_to(input int target);
        int k = 0;
        while (last_cnt != target && k < 200) begin
            step(1'b0, 1'b0, value, dp_in);
            k++;
        end
        check("run_to_reached", last_cnt, target);
    endtask

    // Step until the output reflects cnt==target, requiring a fixed digit on every step.
    task automatic run_check(input int target, input logic [3:0] exp_dig, input string name);
        int k = 0;
        do begin
            step(1'b0, 1'b0, value, dp_in);
            check(name, digit, exp_dig);
            k++;
        end while (last_cnt != target && k < 200);
        check("run_check_reached", last_cnt, target);
    endtask

    // Watch one full frame and check each slot mid-way against an expected lit mask.
    task automatic check_frame(input logic [15:0] val, input logic [3:0] dpi, input logic [3:0] lit, input string tag);
        logic [3:0]  e_an;
        logic [15:0] sh;
        logic [3:0]  e_dig;
        logic        e_dp;
        int s;
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b0, value, dp_in);
            if (last_cnt % 16 == 8) begin
                s     = last_cnt / 16;
                e_an  = lit[s] ? ~(4'(1) << s) : 4'hF;
                sh    = val >> (4 * s);
                e_dig = sh[3:0];
                e_dp  = ~dpi[s];
                check({tag, "_an"}, an, e_an);
                check({tag, "_digit"}, digit, e_dig);
                check({tag, "_dp"}, dp, e_dp);
            end
        end
    endtask

    initial begin
        logic [3:0]  exp_an;
        logic [15:0] rv;
        logic        rr;
        logic        rl;

        tbl[0] = '{16'hA5C3, 4'b0100, 1'b0, 4'b1111};
        tbl[1] = '{16'h0040, 4'b0000, 1'b1, 4'b0011};
        tbl[2] = '{16'h0000, 4'b0001, 1'b1, 4'b0001};
        tbl[3] = '{16'h0000, 4'b0000, 1'b0, 4'b1111};
        tbl[4] = '{16'h0A00, 4'b0010, 1'b1, 4'b0111};
        tbl[5] = '{16'h1000, 4'b1111, 1'b1, 4'b1111};
        tbl[6] = '{16'h000F, 4'b1000, 1'b1, 4'b0001};

        reset = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;

        // Reset held three clocks, then the scan start sequence edge by edge.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
        check("rst_an", an, 4'hF);
        check("rst_digit", digit, 4'h0);
        check("rst_dp", dp, 1'b1);
        for (int e = 1; e <= 20; e++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
            exp_an = (e >= 3 && e <= 16) ? 4'hE : ((e >= 19) ? 4'hD : 4'hF);
            check("rst_seq_an", an, exp_an);
        end

        // Table of display patterns, each loaded and observed over the following frame.
        for (int t = 0; t < 7; t++) begin
            blank_lz = tbl[t].blz;
            step(1'b0, 1'b1, tbl[t].val, tbl[t].dpi);
            run_to(63);
            check_frame(tbl[t].val, tbl[t].dpi, tbl[t].lit, "tbl");
        end

        // Frame sync: mid-frame load waits for the next frame; boundary load shows immediately after.
        blank_lz = 1'b0;
        step(1'b0, 1'b1, 16'h7777, 4'h0);
        run_to(63);
        run_to(30);
        step(1'b0, 1'b1, 16'h1111, 4'h0);
        run_check(63, 4'h7, "fs_old_value");
        run_check(62, 4'h1, "fs_new_value");
        step(1'b0, 1'b1, 16'h2222, 4'h0);
        check("fs_load_on_cnt63", last_cnt, 63);
        run_check(63, 4'h2, "fs_boundary_value");

        // Load collision: two consecutive loads, only the last is displayed.
        run_to(20);
        step(1'b0, 1'b1, 16'hFFFF, 4'h0);
        step(1'b0, 1'b1, 16'h1234, 4'h0);
        run_to(63);
        check_frame(16'h1234, 4'h0, 4'b1111, "coll");

        // Reset in slot 2 restarts the scan at slot 0 with cleared value.
        step(1'b0, 1'b1, 16'h9876, 4'hF);
        run_to(63);
        run_to(40);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        check("ms_rst_an", an, 4'hF);
        check("ms_rst_digit", digit, 4'h0);
        check("ms_rst_dp", dp, 1'b1);
        step(1'b0, 1'b0, 16'h0, 4'h0);
        check("ms_first_an", an, 4'hF);
        step(1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b0, 16'h0, 4'h0);
        check("ms_slot0_an", an, 4'hE);
        check("ms_slot0_digit", digit, 4'h0);
        check("ms_slot0_dp", dp, 1'b1);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rv = 16'h0;
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(1, 0) == 1) rv = rv | (16'($urandom_range(15, 1)) << (4 * n));
            end
            rr = ($urandom_range(599, 0) == 0);
            rl = ($urandom_range(24, 0) == 0);
            if ($urandom_range(99, 0) == 0) blank_lz = ~blank_lz;
            step(rr, rl, rv, 4'($urandom_range(15, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan.md
# sseg_scan

Four-digit time-multiplexing scanner for the board's common-anode seven-segment display. Sits directly upstream of the hex-to-segment decoder. It holds a 16-bit hex value and four decimal-point flags, and rotates through the digits at a refresh rate. Each cycle it presents one nibble and its active-low dp to the decoder and drives the matching active-low anode. Value updates are frame-synchronised to avoid tearing, and a per-slot blanking guard suppresses ghosting.

## Interface
- REFRESH_BITS, 18, width of the free-running scan counter; one full frame is 2^REFRESH_BITS clocks (about 2.6 ms at 100 MHz); legal values are ≥ 4
- BLANK_CYCLES, 64, clocks at the start of each digit slot with all anodes off; legal range is 0 to 2^(REFRESH_BITS-2) - 1
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe; captures value and dp_in
- value  in  16  hex value to display; [3:0] is the rightmost digit (digit 0)
- dp_in  in  4  decimal-point enables, active-high; bit i belongs to digit i
- blank_lz  in  1  when high, leading zero digits are blanked
- an  out  4  anode enables, active-low; an[i] drives digit i
- digit  out  4  nibble for the decoder
- dp  out  1  decimal point to the decoder, active-low (0 = lit)

## Operation
- Counter cnt is REFRESH_BITS wide, free-running, and wraps from all-ones to 0.
  - Slot index: sel = cnt[REFRESH_BITS-1:REFRESH_BITS-2].
  - Slot phase: ph = cnt[REFRESH_BITS-3:0].
- Pending registers pend_val[15:0] and pend_dp[3:0] load from value and dp_in when load=1.
- Active registers act_val and act_dp update only on the frame-boundary cycle, i.e. when cnt is all-ones and wraps next edge.
  - On that cycle, act takes value/dp_in directly if load=1 in the same cycle; otherwise it takes pend.
  - A load on the boundary therefore appears in the very next frame. Pend is also updated.
- Leading-zero mask, computed from act_val:
  - z3 = (act_val[15:12]==0).
  - z2 = z3 & (act_val[11:8]==0).
  - z1 = z2 & (act_val[7:4]==0).
  - Digit i (i = 1..3) is suppressed when blank_lz & z_i. Digit 0 is never suppressed.
- Registered outputs, updated every clock from the current cnt, sel, act and mask:
  - digit = act_val[4*sel +: 4].
  - dp = ~act_dp[sel].
  - an = 4'b1111 if ph < BLANK_CYCLES or digit sel is suppressed; otherwise an = ~(4'b0001 << sel).
- At most one an bit is low at any time. digit and dp follow sel even while the anode is blanked.
- No state machine beyond the counter. Operation is continuous, with no handshake back-pressure. load is accepted on any cycle.

## Timing
- Reset values:
  - cnt = 0.
  - pend_val = act_val = 0.
  - pend_dp = act_dp = 0.
  - an = 4'b1111, digit = 0, dp = 1.
- Output latency is 1 clock from cnt: outputs at edge k+1 reflect cnt value k.
- First edge after reset deasserts (cnt=0, BLANK_CYCLES>0): an stays 1111, digit=0, dp=1.
- With BLANK_CYCLES=0, an[0] goes low on the first edge after reset.
- Slot length is 2^(REFRESH_BITS-2) clocks. Visible on-time per slot is that length minus BLANK_CYCLES.
- load to display: value becomes visible from the first frame starting after the load edge, i.e. at the first cnt=0 slot following it. Maximum delay is one frame.
- Back-to-back loads within one frame: only the last one is displayed.
- Reset mid-frame: on the next edge all registers return to their reset values, and scan restarts at slot 0.

## Test plan
Use REFRESH_BITS=6 and BLANK_CYCLES=2 (slot = 16 clocks, frame = 64 clocks).

- **Reset:** hold reset 3 clocks, then release. Expect an=1111, digit=0, dp=1 immediately. Expect an=1110 from the 3rd edge after release until edge 17. Expect an=1111 at edges 17–18, then an=1101.
- **Scan:**
  - Load value=16'hA5C3, dp_in=4'b0100, blank_lz=0; wait for the next frame.
  - Expect digit=3, 4'hC, 4'h5, 4'hA in slots 0–3 with an=1110, 1101, 1011, 0111.
  - Expect dp=0 only in slot 2.
- **Frame sync:**
  - Load 16'h1111 at mid-frame. Expect the current frame to keep showing the old value; 16'h1111 appears only from the following slot 0.
  - Load 16'h2222 exactly on the cnt=63 cycle. Expect 16'h2222 shown in the next frame.
- **Leading-zero blanking:**
  - With value=16'h0040 and blank_lz=1: an stays 1111 in slots 2 and 3, and digits 0 and 1 are lit.
  - With value=16'h0000: only digit 0 is lit (shows 0).
  - With blank_lz=0: all four digits are lit.
- **Load collision:** assert load with value=16'hFFFF in two consecutive cycles, the second with 16'h1234. Expect 16'h1234 displayed; check the anode one-hot-low invariant on every cycle.
- **Reset mid-scan:** pulse reset during slot 2. Expect outputs to return to reset values on the next edge, act_val=0, and the scan to restart at slot 0.
